adc_serial_packer: RTL
======================

// Module: adc_serial_packer
// PURPOSE
//  Parametrised successor to the quad ADC capture path. Deserialises N-channel, multi-lane,
//  MSB-first serial ADC words aligned by a frame marker, and buffers complete sample sets in a FIFO.
//  Streams the sets out as packed AXI-Stream beats with packet framing (tlast).
//  Sits between the ADC LVDS pins and the DMA stream input; everything runs on the bit clock.
// PARAMETERS
//  NUM_CHANNELS          4    ADC channels captured in parallel
//  SAMPLE_BITS           14   bits per sample; SAMPLE_BITS % LANES == 0, SAMPLE_BITS <= 16
//  LANES                 2    serial lanes per channel
//  C_M_AXIS_TDATA_WIDTH  32   stream width; (NUM_CHANNELS*16) % C_M_AXIS_TDATA_WIDTH == 0
//  SIGNED_OUT            0    0: zero-extend each sample to 16 bits; 1: sign-extend from bit SAMPLE_BITS-1
//  PACKET_SETS           256  sample sets per packet (tlast period), >= 1
//  FIFO_DEPTH            16   sample-set FIFO depth, power of 2
// PORTS
//  m00_axis_aclk     in   1                       bit clock; all logic on rising edge
//  m00_axis_areset   in   1                       asynchronous, active-high reset
//  frame_in          in   1                       frame marker; rising edge marks first bit group of a word
//  lane_in           in   NUM_CHANNELS*LANES      lane_in[c*LANES+l] = channel c, lane l
//  capture_en        in   1                       accept completed words when 1
//  m00_axis_tvalid   out  1                       stream valid
//  m00_axis_tdata    out  C_M_AXIS_TDATA_WIDTH    packed samples
//  m00_axis_tlast    out  1                       last beat of packet
//  m00_axis_tready   in   1                       stream ready
//  drop_count        out  16                      sets lost to a full FIFO, saturating
//  resync_count      out  16                      frame edges seen mid-word, saturating
//  fifo_level        out  $clog2(FIFO_DEPTH)+1    sets currently buffered
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FIFO empty, counters 0, capture FSM in HUNT,
//   packet set count 0. Reset mid-packet discards the partial packet; the next beat starts a new packet.
//  Frame edge: frame_in==1 with its registered previous value ==0, detected combinationally in the same cycle.
//  Capture FSM, W = SAMPLE_BITS/LANES cycles per word:
//   HUNT: ignore lanes until a frame edge; on the edge capture the first group, bitcnt=1, go to SHIFT.
//   SHIFT: each cycle, per channel, sr = {sr, lane l=0..LANES-1}; lane 0 carries the higher bit.
//    When bitcnt reaches W the word is complete; bitcnt=0.
//    Frame edge with bitcnt==0: normal; capture as the first group.
//    Frame edge with 0<bitcnt<W: discard the partial word, resync_count++, capture as the first group.
//    bitcnt==0 with no edge: remain in SHIFT, no capture until the next edge.
//  Word complete in cycle k: if capture_en==1 in cycle k, the set is written to the FIFO at edge k+1;
//   otherwise it is discarded silently.
//   FIFO full at write time: set dropped, drop_count++ (saturates at 16'hFFFF).
//   Simultaneous FIFO read and write when full: the write succeeds.
//  Packing: each sample is extended to 16 bits per SIGNED_OUT. Beat b holds channels
//   b*C/16 .. ; lowest channel in the LSBs. BEATS = NUM_CHANNELS*16/C_M_AXIS_TDATA_WIDTH per set.
//  Output FSM:
//   IDLE: FIFO non-empty -> pop the set, go to SEND with tvalid=1 at beat 0.
//   SEND: tvalid, tdata, tlast are held stable until tready. Each accepted beat advances the beat index.
//    After the last beat: pop the next set if available (no bubble), else return to IDLE.
//  Latency: word complete at cycle k, FIFO and output idle -> first beat tvalid in cycle k+2.
//  tlast=1 on the final beat of every PACKET_SETS-th emitted set. The set counter wraps to 0 after that beat.
//  Dropped and disabled sets do not advance the packet count.
//  fifo_level counts sets in the FIFO, excluding the set being sent.
// TESTING
//  T1 defaults, one word per channel 0x0A1,0x0B1,0x0C1,0x0D1 with tready=1:
//   beats 0x00B100A1 then 0x00D100C1, tlast=0, first tvalid 2 cycles after the 7th bit group.
//  T2 SIGNED_OUT=1, ch0 sample 14'h2001 -> beat0[15:0]=16'hE001; SIGNED_OUT=0 -> 16'h2001.
//  T3 tready=0, 20 consecutive words -> fifo_level saturates at 16 (one set held in SEND excluded);
//   drop_count=3; after tready=1, 17 sets emit in order.
//  T4 PACKET_SETS=4, 8 words streamed -> tlast high only on beats 8 and 16; tvalid gap-free across sets.
//  T5 frame edge after 3 bit groups of a word -> resync_count=1, partial word not emitted;
//   the following word 0x0A2.. emits correctly.
//  T6 assert m00_axis_areset mid-packet with 3 sets buffered -> outputs and counters 0 immediately;
//   after release, first word emitted; tlast counts from a fresh packet.

Source files
------------

// File: rtl/adc_serial_packer.sv
//==============================================================================
// Module      : adc_serial_packer
// Description : Multi-channel, multi-lane serial ADC deserialiser. Frame-aligned
//               MSB-first words are assembled per channel, buffered as complete
//               sample sets in a FIFO and streamed out as packed AXI-Stream
//               beats with tlast every PACKET_SETS sets. Single clock domain
//               (the ADC bit clock).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adc_serial_packer #(
  parameter int NUM_CHANNELS         = 4,
  parameter int SAMPLE_BITS          = 14,
  parameter int LANES                = 2,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int SIGNED_OUT           = 0,
  parameter int PACKET_SETS          = 256,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                              m00_axis_aclk,
  input  logic                              m00_axis_areset,
  input  logic                              frame_in,
  input  logic [NUM_CHANNELS*LANES-1:0]     lane_in,
  input  logic                              capture_en,
  output logic                              m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  output logic [15:0]                       drop_count,
  output logic [15:0]                       resync_count,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  // Derived sizes
  localparam int c_WORD_CYC = SAMPLE_BITS / LANES;
  localparam int c_CNT_W    = $clog2(c_WORD_CYC + 1);
  localparam int c_SET_W    = NUM_CHANNELS * 16;
  localparam int c_BEATS    = c_SET_W / C_M_AXIS_TDATA_WIDTH;
  localparam int c_BEAT_W   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_PKT_W    = (PACKET_SETS > 1) ? $clog2(PACKET_SETS) : 1;
  localparam int c_ADDR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_LVL_W    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [c_CNT_W-1:0]  c_WORD_CNT  = c_CNT_W'(c_WORD_CYC);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(c_BEATS - 1);
  localparam logic [c_PKT_W-1:0]  c_PKT_LAST  = c_PKT_W'(PACKET_SETS - 1);
  localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = c_ADDR_W'(FIFO_DEPTH - 1);
  localparam logic [c_LVL_W-1:0]  c_LVL_FULL  = c_LVL_W'(FIFO_DEPTH);

  // Capture FSM encoding
  localparam logic [0:0] c_ST_HUNT  = 1'b0;
  localparam logic [0:0] c_ST_SHIFT = 1'b1;

  // Output FSM encoding
  localparam logic [0:0] c_OST_IDLE = 1'b0;
  localparam logic [0:0] c_OST_SEND = 1'b1;

  //--------------------------------------------------------------------------
  // Frame edge detection and capture control
  //--------------------------------------------------------------------------
  logic                 r_frame_prev;
  logic [0:0]           r_cap_state;
  logic [c_CNT_W-1:0]   r_bitcnt;
  logic [15:0]          r_resync_cnt;

  logic                 w_frame_edge;
  logic                 w_shift_en;
  logic [c_CNT_W-1:0]   w_bitcnt_inc;
  logic                 w_word_done;
  logic                 w_resync;
  logic [c_SET_W-1:0]   w_set;

  assign w_frame_edge = frame_in & ~r_frame_prev;
  // A group is taken on every frame edge, and mid-word while the count is
  // non-zero; bitcnt==0 without an edge means "wait for the next frame".
  assign w_shift_en   = w_frame_edge | ((r_cap_state == c_ST_SHIFT) && (r_bitcnt != '0));
  assign w_bitcnt_inc = w_frame_edge ? c_CNT_W'(1) : (r_bitcnt + c_CNT_W'(1));
  assign w_word_done  = w_shift_en && (w_bitcnt_inc == c_WORD_CNT);
  assign w_resync     = w_frame_edge && (r_cap_state == c_ST_SHIFT) && (r_bitcnt != '0);

  // Remember the previous frame level for edge detection
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) r_frame_prev <= 1'b0;
    else                 r_frame_prev <= frame_in;
  end

  // Capture FSM: hunt for the first frame edge, then count bit groups per word
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      r_cap_state <= c_ST_HUNT;
      r_bitcnt    <= '0;
    end else begin
      if (w_frame_edge) r_cap_state <= c_ST_SHIFT;
      if (w_shift_en)   r_bitcnt    <= w_word_done ? '0 : w_bitcnt_inc;
    end
  end

  // Count frame edges that cut a word short, saturating
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset)                        r_resync_cnt <= '0;
    else if (w_resync && (r_resync_cnt != 16'hFFFF)) r_resync_cnt <= r_resync_cnt + 16'd1;
  end

  //--------------------------------------------------------------------------
  // Per-channel shift registers and 16-bit extension
  //--------------------------------------------------------------------------
  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [LANES-1:0]       w_group;
      logic [SAMPLE_BITS-1:0] w_word;

      // Lane 0 carries the most significant bit of each group
      for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_group[LANES-1-l] = lane_in[c*LANES+l];
      end

      if (SAMPLE_BITS > LANES) begin : g_sr
        logic [SAMPLE_BITS-LANES-1:0] r_sr;

        // The word in flight is the retained history with the new group appended
        assign w_word = {r_sr, w_group};

        // Keep the most recent bits; older bits fall off the top
        always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
          if (m00_axis_areset) r_sr <= '0;
          else if (w_shift_en) r_sr <= w_word[SAMPLE_BITS-LANES-1:0];
        end
      end else begin : g_nosr
        assign w_word = w_group;
      end

      if (SAMPLE_BITS == 16) begin : g_full
        assign w_set[c*16 +: 16] = w_word;
      end else if (SIGNED_OUT != 0) begin : g_sext
        assign w_set[c*16 +: 16] = {{(16-SAMPLE_BITS){w_word[SAMPLE_BITS-1]}}, w_word};
      end else begin : g_zext
        assign w_set[c*16 +: 16] = {{(16-SAMPLE_BITS){1'b0}}, w_word};
      end
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Sample-set FIFO
  //--------------------------------------------------------------------------
  logic [c_SET_W-1:0]  r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_addr;
  logic [c_ADDR_W-1:0] r_rd_addr;
  logic [c_LVL_W-1:0]  r_level;
  logic [15:0]         r_drop_cnt;

  logic w_wr_req;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr_ok;
  logic w_drop;

  assign w_wr_req = w_word_done & capture_en;
  assign w_full   = (r_level == c_LVL_FULL);
  assign w_empty  = (r_level == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr_ok  = w_wr_req & (~w_full | w_pop);
  assign w_drop   = w_wr_req & w_full & ~w_pop;

  // Set storage; contents need no reset because level gates every read
  always_ff @(posedge m00_axis_aclk) begin
    if (w_wr_ok) r_mem[r_wr_addr] <= w_set;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_level   <= '0;
    end else begin
      if (w_wr_ok) r_wr_addr <= (r_wr_addr == c_ADDR_LAST) ? '0 : (r_wr_addr + c_ADDR_W'(1));
      if (w_pop)   r_rd_addr <= (r_rd_addr == c_ADDR_LAST) ? '0 : (r_rd_addr + c_ADDR_W'(1));
      case ({w_wr_ok, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Count sets lost to a full FIFO, saturating
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset)                          r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  //--------------------------------------------------------------------------
  // Output stream FSM
  //--------------------------------------------------------------------------
  logic [0:0]          r_out_state;
  logic [c_SET_W-1:0]  r_set;
  logic [c_BEAT_W-1:0] r_beat;
  logic [c_PKT_W-1:0]  r_pkt_cnt;

  logic w_beat_last;
  logic w_accept;
  logic w_set_end;

  assign w_beat_last = (r_beat == c_BEAT_LAST);
  assign w_accept    = (r_out_state == c_OST_SEND) && m00_axis_tready;
  assign w_set_end   = w_accept && w_beat_last;
  // Pop from IDLE, or back-to-back as the last beat of the current set leaves
  assign w_pop       = ~w_empty && ((r_out_state == c_OST_IDLE) || w_set_end);

  // Load sets from the FIFO and walk through their beats
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      r_out_state <= c_OST_IDLE;
      r_set       <= '0;
      r_beat      <= '0;
    end else if (w_pop) begin
      r_out_state <= c_OST_SEND;
      r_set       <= r_mem[r_rd_addr];
      r_beat      <= '0;
    end else if (w_set_end) begin
      r_out_state <= c_OST_IDLE;
      r_beat      <= '0;
    end else if (w_accept) begin
      r_beat      <= r_beat + c_BEAT_W'(1);
    end
  end

  // Packet position: advances once per fully emitted set
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset)  r_pkt_cnt <= '0;
    else if (w_set_end)   r_pkt_cnt <= (r_pkt_cnt == c_PKT_LAST) ? '0 : (r_pkt_cnt + c_PKT_W'(1));
  end

  // Select the current beat from the held set; lowest channels in beat 0
  always_comb begin
    m00_axis_tdata = '0;
    for (int b = 0; b < c_BEATS; b++) begin
      if (r_beat == c_BEAT_W'(b)) m00_axis_tdata = r_set[b*C_M_AXIS_TDATA_WIDTH +: C_M_AXIS_TDATA_WIDTH];
    end
  end

  assign m00_axis_tvalid = (r_out_state == c_OST_SEND);
  assign m00_axis_tlast  = (r_out_state == c_OST_SEND) && w_beat_last && (r_pkt_cnt == c_PKT_LAST);
  assign drop_count      = r_drop_cnt;
  assign resync_count    = r_resync_cnt;
  assign fifo_level      = r_level;

endmodule

`default_nettype wire
